// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator keypad controller.
package calc_pkg;

  typedef enum logic [1:0] {
    S_OPA    = 2'd0,
    S_OPB    = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_e;

  localparam logic [4:0] KEY_ADD  = 5'h10;
  localparam logic [4:0] KEY_MUL  = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;
  localparam logic [4:0] KEY_NONE = 5'h1F;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  function automatic logic is_operator(input logic [4:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_AND) ||
           (key == KEY_SUB) || (key == KEY_OR);
  endfunction

  function automatic alu_op_e key_to_op(input logic [4:0] key);
    alu_op_e op;
    case (key)
      KEY_SUB: op = ALU_SUB;
      KEY_MUL: op = ALU_MUL;
      KEY_AND: op = ALU_AND;
      KEY_OR:  op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-cycle pulse on a rising edge of a level input.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/calc_controller.sv
// Keypad-driven operand entry and sequencing for a 16-bit calculator with an external ALU.
module calc_controller
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [4:0]  val,
  input  logic        hex_mode,
  input  logic [15:0] alu_result,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  alu_op,
  output logic [15:0] display_value,
  output logic [1:0]  state_led,
  output logic        restriction
);

  logic        accept;
  state_e      state_q, state_d;
  logic [15:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  alu_op_e     alu_op_q, alu_op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        is_digit, digit_ok, room;

  edge_detect u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (select),
    .rise_o (accept)
  );

  assign is_digit = ~val[4];
  assign digit_ok = mode_q | (val[3:0] <= 4'd9);
  assign room     = cnt_q < MAX_DIGITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OPA;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      alu_op_q <= ALU_ADD;
      cnt_q    <= '0;
      mode_q   <= hex_mode;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      alu_op_q <= alu_op_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    alu_op_d = alu_op_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    // Entry radix may only change before the first digit of op_a.
    if (state_q == S_OPA && cnt_q == '0) mode_d = hex_mode;

    if (accept) begin
      if (is_digit) begin
        if (digit_ok) begin
          case (state_q)
            S_OPA: if (room) begin
              op_a_d = {op_a_q[11:0], val[3:0]};
              cnt_d  = cnt_q + 3'd1;
            end
            S_OPB: if (room) begin
              op_b_d = {op_b_q[11:0], val[3:0]};
              cnt_d  = cnt_q + 3'd1;
            end
            default: begin
              op_a_d  = {12'h000, val[3:0]};
              cnt_d   = 3'd1;
              state_d = S_OPA;
            end
          endcase
        end
      end else if (is_operator(val)) begin
        case (state_q)
          S_OPA: begin
            alu_op_d = key_to_op(val);
            op_b_d   = '0;
            cnt_d    = '0;
            state_d  = S_OPB;
          end
          S_OPB: if (cnt_q == '0) alu_op_d = key_to_op(val);
          default: begin
            op_a_d   = result_q;
            alu_op_d = key_to_op(val);
            op_b_d   = '0;
            cnt_d    = '0;
            state_d  = S_OPB;
          end
        endcase
      end else if (val == KEY_EXE) begin
        if (state_q == S_OPB) begin
          result_d = alu_result;
          state_d  = S_RESULT;
        end
      end else if (val == KEY_CE && state_q == S_OPA) begin
        op_a_d = '0;
        cnt_d  = '0;
      end else if (val == KEY_CE && state_q == S_OPB) begin
        op_b_d = '0;
        cnt_d  = '0;
      end else if (val == KEY_CE || val == KEY_CLR) begin
        state_d  = S_OPA;
        op_a_d   = '0;
        op_b_d   = '0;
        result_d = '0;
        alu_op_d = ALU_ADD;
        cnt_d    = '0;
        mode_d   = hex_mode;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_OPB:    display_value = op_b_q;
      S_RESULT: display_value = result_q;
      default:  display_value = op_a_q;
    endcase
    state_led   = state_q;
    restriction = ~mode_q;
  end

  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_calc_controller.sv
// Randomised key sequences checked against a behavioural calculator model.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        select = 1'b0;
  logic [4:0]  val = 5'h1F;
  logic        hex_mode = 1'b1;
  logic [15:0] alu_result;
  logic [15:0] op_a, op_b, display_value;
  logic [2:0]  alu_op;
  logic [1:0]  state_led;
  logic        restriction;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: st 0=enter A, 1=enter B, 2=showing result.
  int m_st, m_a, m_b, m_res, m_op, m_cnt, m_mode;

  calc_controller dut (
    .clk           (clk),
    .rst           (rst),
    .select        (select),
    .val           (val),
    .hex_mode      (hex_mode),
    .alu_result    (alu_result),
    .op_a          (op_a),
    .op_b          (op_b),
    .alu_op        (alu_op),
    .display_value (display_value),
    .state_led     (state_led),
    .restriction   (restriction)
  );

  always #5 clk = ~clk;

  function automatic int calc(input int a, input int b, input int op);
    case (op)
      0: return (a + b) & 16'hFFFF;
      1: return (a - b) & 16'hFFFF;
      2: return (a * b) & 16'hFFFF;
      3: return a & b;
      4: return a | b;
      default: return 0;
    endcase
  endfunction

  // External ALU environment.
  always_comb alu_result = 16'(calc(int'(op_a), int'(op_b), int'(alu_op)));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_cnt = 0; m_mode = int'(hex_mode);
  endtask

  function automatic int op_code(input int k);
    case (k)
      'h10: return 0;
      'h14: return 1;
      'h11: return 2;
      'h12: return 3;
      'h15: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_key(input int k);
    if (m_st == 0 && m_cnt == 0) m_mode = int'(hex_mode);
    if (k < 16) begin
      if (m_mode == 1 || k <= 9) begin
        if (m_st == 2) begin
          m_a = k; m_cnt = 1; m_st = 0;
        end else if (m_cnt < 4) begin
          if (m_st == 0) m_a = ((m_a << 4) | k) & 16'hFFFF;
          else           m_b = ((m_b << 4) | k) & 16'hFFFF;
          m_cnt++;
        end
      end
    end else if (op_code(k) >= 0) begin
      if (m_st == 0) begin
        m_op = op_code(k); m_b = 0; m_cnt = 0; m_st = 1;
      end else if (m_st == 1) begin
        if (m_cnt == 0) m_op = op_code(k);
      end else begin
        m_a = m_res; m_op = op_code(k); m_b = 0; m_cnt = 0; m_st = 1;
      end
    end else if (k == 'h13) begin
      if (m_st == 1) begin
        m_res = calc(m_a, m_b, m_op); m_st = 2;
      end
    end else if (k == 'h16 && m_st == 0) begin
      m_a = 0; m_cnt = 0;
    end else if (k == 'h16 && m_st == 1) begin
      m_b = 0; m_cnt = 0;
    end else if (k == 'h16 || k == 'h17) begin
      model_reset();
    end
    if (m_st == 0 && m_cnt == 0) m_mode = int'(hex_mode);
  endtask

  task automatic compare_model(input string tag);
    int disp;
    disp = (m_st == 0) ? m_a : (m_st == 1) ? m_b : m_res;
    check_eq({tag, ".op_a"},  32'(op_a),  32'(m_a));
    check_eq({tag, ".op_b"},  32'(op_b),  32'(m_b));
    check_eq({tag, ".alu_op"}, 32'(alu_op), 32'(m_op));
    check_eq({tag, ".disp"},  32'(display_value), 32'(disp));
    check_eq({tag, ".state"}, 32'(state_led), 32'(m_st));
    check_eq({tag, ".restr"}, 32'(restriction), 32'(m_mode == 0));
  endtask

  task automatic press(input int k, input int hold);
    @(negedge clk);
    val = 5'(k);
    select = 1'b1;
    repeat (hold) @(negedge clk);
    select = 1'b0;
    val = 5'h1F;
    repeat (2) @(negedge clk);
    model_key(k);
    compare_model($sformatf("key%0h", k));
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    hex_mode = m;
    @(negedge clk);
    if (m_st == 0 && m_cnt == 0) m_mode = int'(m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_model("reset");
  endtask

  initial begin
    int r, k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_model("por");
    check_eq("por.op_a", 32'(op_a), 32'h0);

    // Hex calc 0x12 + 3.
    press('h1, 2); press('h2, 2); press('h10, 2); press('h3, 2); press('h13, 2);
    check_eq("d37.op_a", 32'(op_a), 32'h12);
    check_eq("d37.op_b", 32'(op_b), 32'h3);
    check_eq("d37.disp", 32'(display_value), 32'h15);
    check_eq("d37.state", 32'(state_led), 32'd2);

    // Chaining from a result of 0x15.
    press('h11, 2); press('h2, 2); press('h13, 2);
    check_eq("d41.op_a", 32'(op_a), 32'h15);
    check_eq("d41.alu_op", 32'(alu_op), 32'd2);
    check_eq("d41.disp", 32'(display_value), 32'h2A);

    // Decimal entry ignores A-F.
    set_mode(1'b0);
    press('h17, 2); press('h9, 2); press('hA, 2); press('h5, 2);
    check_eq("d38.op_a", 32'(op_a), 32'h95);
    check_eq("d38.restr", 32'(restriction), 32'd1);

    // Five digits keep the first four.
    set_mode(1'b1);
    press('h17, 2); press('h1, 2); press('h2, 2); press('h3, 2); press('h4, 2); press('h5, 2);
    check_eq("d39.op_a", 32'(op_a), 32'h1234);

    // Operator replacement, then CE of op_b.
    press('h17, 2); press('h7, 2); press('h10, 2); press('h14, 2); press('h2, 2);
    check_eq("d40.alu_op", 32'(alu_op), 32'd1);
    check_eq("d40.op_b", 32'(op_b), 32'h2);
    press('h4, 2); press('h5, 2); press('h16, 2);
    check_eq("d42.op_b", 32'(op_b), 32'h0);
    check_eq("d42.state", 32'(state_led), 32'd1);

    // Long hold accepts once.
    press('h17, 2); press('h1, 10);
    check_eq("d43.op_a", 32'(op_a), 32'h1);

    // Reset beats a simultaneous key.
    press('h3, 2);
    @(negedge clk);
    val = 5'h5; select = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; select = 1'b0; val = 5'h1F;
    @(negedge clk);
    model_reset();
    compare_model("d44");
    check_eq("d44.op_a", 32'(op_a), 32'h0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) do_reset();
      else if (r < 10) set_mode(1'($urandom_range(0, 1)));
      else begin
        if ($urandom_range(0, 99) < 55) k = $urandom_range(0, 15);
        else k = $urandom_range(16, 31);
        press(k, $urandom_range(1, 4));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
